// File: rtl/playback_pkg.sv
// Shared defaults for the record/playback datapath so the buffer and controller
// agree on sample width, FIFO depth and tick period.
package playback_pkg;

   localparam int WIDTH_DEF       = 32'd8;
   localparam int DEPTH_DEF       = 32'd16;
   localparam int TICK_CYCLES_DEF = 32'd50_000_000;

   // Encoded as {push, pop} so the top can cast the two qualifiers directly.
   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/tick_timer.sv
// Free-running playback tick: one-cycle pulse every TICK_CYCLES clocks while
// timer_enable is held; counter clears as soon as the enable drops.
module tick_timer
   import playback_pkg::*;
#(
   parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic timer_enable,
   output logic timer
);

   localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

   logic [CW-1:0] cnt_r;

   // Counter and registered tick pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= '0;
         timer <= 1'b0;
      end else if (!timer_enable) begin
         cnt_r <= '0;
         timer <= 1'b0;
      end else if (cnt_r == CW'(TICK_CYCLES - 1)) begin
         cnt_r <= '0;
         timer <= 1'b1;
      end else begin
         cnt_r <= cnt_r + CW'(1);
         timer <= 1'b0;
      end
   end

endmodule

// File: rtl/playback_buffer.sv
// Circular sample FIFO for record/playback: pushes on write_enable, releases
// one sample per playback tick while read_enable is high.
module playback_buffer
   import playback_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       write_enable,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       read_enable,
   input  logic                       timer_enable,
   output logic                       timer,
   output logic [WIDTH-1:0]           data_out,
   output logic                       data_valid,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_s;
   logic             pop_s;
   fifo_op_e         op_s;

   tick_timer #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_tick_timer (
      .clk          (clk),
      .reset        (reset),
      .timer_enable (timer_enable),
      .timer        (timer)
   );

   assign empty = (count_r == CW'(0));
   assign full  = (count_r == CW'(DEPTH));
   assign count = count_r;

   // Qualify requests against registered status, so an empty FIFO never
   // falls through and a full FIFO never accepts a push in the pop cycle.
   always_comb begin
      push_s = write_enable & ~full;
      pop_s  = read_enable & timer & ~empty;
      op_s   = fifo_op_e'({push_s, pop_s});
   end

   // Sample storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         case (op_s)
            OP_PUSH: begin
               wr_ptr_r <= wr_ptr_r + AW'(1);
               count_r  <= count_r + CW'(1);
            end
            OP_POP: begin
               rd_ptr_r <= rd_ptr_r + AW'(1);
               count_r  <= count_r - CW'(1);
            end
            OP_BOTH: begin
               wr_ptr_r <= wr_ptr_r + AW'(1);
               rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   // Output sample register with one-cycle valid strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (pop_s) begin
         data_out   <= mem_r[rd_ptr_r];
         data_valid <= 1'b1;
      end else begin
         data_valid <= 1'b0;
      end
   end

endmodule
